mips_fetch_stage: RTL and testbench

//  IF stage of the pipelined MIPS CPU, directly upstream of decode (ID).
//  - Owns the PC and drives the instruction-memory address.
//  - Captures fetched words into the IF/ID pipeline register.
//  - Honours the hazard unit's STALL and the EX-stage branch/jump REDIRECT.
//  - Drains and halts the front end when a BREAK instruction is fetched.

---
 rtl/mips_pkg.sv | 34 +++
 rtl/mips_ifid_reg.sv | 43 ++++
 rtl/mips_fetch_stage.sv | 162 ++++++++++++++++
 tb/tb_mips_fetch_stage.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline front end.
// Holds the instruction-field constants needed to spot BREAK, the fetch
// state encoding, and the layout of the instruction/PC+4/valid pipeline
// register that sits between stages.
package mips_pkg;

  localparam logic [5:0]  OPC_RTYPE   = 6'h00;
  localparam logic [5:0]  FUNCT_BREAK = 6'h0D;
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH_BOOT  = 2'd0,
    FETCH_RUN   = 2'd1,
    FETCH_DRAIN = 2'd2,
    FETCH_HALT  = 2'd3
  } fetch_state_e;

  // 65-bit pipeline payload: instruction word, its PC+4, and a valid flag.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
  } ifid_t;

  // A bubble looks exactly like the reset contents of the register.
  localparam ifid_t IFID_BUBBLE = '{instr: NOP_INSTR, pc4: 32'h0, valid: 1'b0};

  // BREAK is an R-type (opcode 0) with funct 0x0D; the code field in
  // bits 25:6 is irrelevant.
  function automatic logic is_break(input logic [31:0] instr);
    return (instr[31:26] == OPC_RTYPE) && (instr[5:0] == FUNCT_BREAK);
  endfunction

endpackage

// File: rtl/mips_ifid_reg.sv
// Generic instruction/PC+4/valid pipeline register between two stages.
// Ports:
//   clk    in   clock, rising edge
//   rst    in   synchronous active-high reset, loads a bubble
//   hold   in   keep the current contents (downstream stall)
//   flush  in   load a bubble; wins over hold
//   d_in   in   payload to capture when neither hold nor flush
//   q_out  out  registered payload
module mips_ifid_reg
  import mips_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  hold,
  input  logic  flush,
  input  ifid_t d_in,
  output ifid_t q_out
);

  ifid_t ifid_d;
  ifid_t ifid_q;

  // Flush squashes whatever would otherwise be kept or captured.
  always_comb begin
    ifid_d = d_in;
    if (flush) begin
      ifid_d = IFID_BUBBLE;
    end else if (hold) begin
      ifid_d = ifid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ifid_q <= IFID_BUBBLE;
    end else begin
      ifid_q <= ifid_d;
    end
  end

  assign q_out = ifid_q;

endmodule

// File: rtl/mips_fetch_stage.sv
// IF stage of the pipelined MIPS CPU.
// Owns the PC, presents it to an asynchronous instruction ROM, and captures
// the returned word into the IF/ID register. Honours hazard stalls and EX
// redirects, and drains/halts the front end after fetching BREAK.
// Ports:
//   CLK          in   clock, all state on rising edge
//   RST          in   synchronous active-high reset
//   STALL        in   hold PC and IF/ID this cycle
//   REDIRECT     in   taken branch/jump: flush IF/ID, load REDIRECT_PC
//   REDIRECT_PC  in   target byte address (low two bits ignored)
//   IMEM_ADDR    out  instruction address, combinationally equal to PC
//   IMEM_DATA    in   instruction word at IMEM_ADDR, same cycle
//   IFID_INSTR   out  registered instruction to ID
//   IFID_PC4     out  registered PC+4 of IFID_INSTR
//   IFID_VALID   out  registered, 0 marks a bubble
//   HALTED       out  registered, front end stopped after BREAK
module mips_fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          BOOT_CYCLES = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        STALL,
  input  logic        REDIRECT,
  input  logic [31:0] REDIRECT_PC,
  output logic [31:0] IMEM_ADDR,
  input  logic [31:0] IMEM_DATA,
  output logic [31:0] IFID_INSTR,
  output logic [31:0] IFID_PC4,
  output logic        IFID_VALID,
  output logic        HALTED
);

  // Counter runs 0..BOOT_CYCLES-1; the last value is the final bubble cycle.
  localparam int              CNT_W     = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] BOOT_LAST = CNT_W'(BOOT_CYCLES - 1);

  fetch_state_e     state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [CNT_W-1:0] boot_cnt_q, boot_cnt_d;
  logic             halted_q, halted_d;

  logic [31:0] pc_plus4;
  logic [31:0] redirect_target;
  logic        boot_done;
  logic        fetch_is_break;
  logic        ifid_hold;
  logic        ifid_flush;
  ifid_t       ifid_in;
  ifid_t       ifid_out;

  assign pc_plus4        = pc_q + 32'd4;
  assign redirect_target = REDIRECT_PC & 32'hFFFF_FFFC;
  assign boot_done       = (boot_cnt_q == BOOT_LAST);
  assign fetch_is_break  = is_break(IMEM_DATA);
  assign ifid_in         = '{instr: IMEM_DATA, pc4: pc_plus4, valid: 1'b1};

  // State register together with the PC, boot counter and halt flag.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= FETCH_BOOT;
      pc_q       <= RESET_PC;
      boot_cnt_q <= '0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      boot_cnt_q <= boot_cnt_d;
      halted_q   <= halted_d;
    end
  end

  // Next state. Redirect beats stall everywhere except BOOT, and HALT
  // ignores stall because nothing is moving anyway.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FETCH_BOOT: begin
        if (boot_done) state_d = FETCH_RUN;
      end
      FETCH_RUN: begin
        if (REDIRECT)            state_d = FETCH_RUN;
        else if (STALL)          state_d = FETCH_RUN;
        else if (fetch_is_break) state_d = FETCH_DRAIN;
      end
      FETCH_DRAIN: begin
        if (REDIRECT)    state_d = FETCH_RUN;
        else if (!STALL) state_d = FETCH_HALT;
      end
      FETCH_HALT: begin
        if (REDIRECT) state_d = FETCH_RUN;
      end
      default: state_d = FETCH_BOOT;
    endcase
  end

  // Per-state datapath controls: next PC, IF/ID hold/flush, halt flag.
  // After BREAK is latched the PC stays parked on it so a redirect or
  // reset is the only way forward.
  always_comb begin
    pc_d       = pc_q;
    boot_cnt_d = boot_cnt_q;
    halted_d   = halted_q;
    ifid_hold  = 1'b0;
    ifid_flush = 1'b0;
    unique case (state_q)
      FETCH_BOOT: begin
        ifid_flush = 1'b1;
        if (!boot_done) boot_cnt_d = boot_cnt_q + CNT_W'(1);
      end
      FETCH_RUN: begin
        if (REDIRECT) begin
          pc_d       = redirect_target;
          ifid_flush = 1'b1;
          halted_d   = 1'b0;
        end else if (STALL) begin
          ifid_hold = 1'b1;
        end else if (!fetch_is_break) begin
          pc_d = pc_plus4;
        end
      end
      FETCH_DRAIN: begin
        if (REDIRECT) begin
          pc_d       = redirect_target;
          ifid_flush = 1'b1;
          halted_d   = 1'b0;
        end else if (STALL) begin
          ifid_hold = 1'b1;
        end else begin
          ifid_flush = 1'b1;
          halted_d   = 1'b1;
        end
      end
      FETCH_HALT: begin
        ifid_flush = 1'b1;
        if (REDIRECT) begin
          pc_d     = redirect_target;
          halted_d = 1'b0;
        end
      end
      default: ifid_flush = 1'b1;
    endcase
  end

  mips_ifid_reg u_ifid_reg (
    .clk   (CLK),
    .rst   (RST),
    .hold  (ifid_hold),
    .flush (ifid_flush),
    .d_in  (ifid_in),
    .q_out (ifid_out)
  );

  assign IMEM_ADDR  = pc_q;
  assign IFID_INSTR = ifid_out.instr;
  assign IFID_PC4   = ifid_out.pc4;
  assign IFID_VALID = ifid_out.valid;
  assign HALTED     = halted_q;

endmodule

// File: tb/tb_mips_fetch_stage.sv
// Directed bench for mips_fetch_stage: a vector table of per-edge inputs
// and expected post-edge outputs, followed by a hand-written halt sequence.
// The instruction ROM is modelled inside the bench.
module tb_mips_fetch_stage;

  logic        CLK;
  logic        RST;
  logic        STALL;
  logic        REDIRECT;
  logic [31:0] REDIRECT_PC;
  logic [31:0] IMEM_ADDR;
  logic [31:0] IMEM_DATA;
  logic [31:0] IFID_INSTR;
  logic [31:0] IFID_PC4;
  logic        IFID_VALID;
  logic        HALTED;

  int check_count;
  int error_count;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
    logic [31:0] exp_pc4;
    logic        exp_valid;
    logic        exp_halted;
  } vec_t;

  vec_t vecs[$];

  mips_fetch_stage #(
    .RESET_PC    (32'h0000_0000),
    .BOOT_CYCLES (1)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .STALL       (STALL),
    .REDIRECT    (REDIRECT),
    .REDIRECT_PC (REDIRECT_PC),
    .IMEM_ADDR   (IMEM_ADDR),
    .IMEM_DATA   (IMEM_DATA),
    .IFID_INSTR  (IFID_INSTR),
    .IFID_PC4    (IFID_PC4),
    .IFID_VALID  (IFID_VALID),
    .HALTED      (HALTED)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ROM: addi-style words {opcode 8, addr[25:0]} everywhere, BREAK at 0x20,
  // and two BREAK look-alikes at 0x44 (wrong opcode) and 0x48 (wrong funct).
  function automatic logic [31:0] rom(input logic [31:0] addr);
    case (addr)
      32'h0000_0020: return 32'h0000_000D;
      32'h0000_0044: return 32'h2000_000D;
      32'h0000_0048: return 32'h0000_0020;
      default:       return {6'h08, addr[25:0]};
    endcase
  endfunction

  always_comb IMEM_DATA = rom(IMEM_ADDR);

  task automatic applyStimulus(input logic rst, input logic stall,
                               input logic redirect, input logic [31:0] rpc);
    RST         = rst;
    STALL       = stall;
    REDIRECT    = redirect;
    REDIRECT_PC = rpc;
    @(posedge CLK);
    #1;
  endtask

  task automatic checkOutput(input string name, input int idx,
                             input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("[TB] FAIL %s step %0d: got %h expected %h", name, idx, actual, expected);
    end
  endtask

  task automatic checkAll(input int idx, input logic [31:0] pc, input logic [31:0] instr,
                          input logic [31:0] pc4, input logic valid, input logic halted);
    checkOutput("imem_addr", idx, IMEM_ADDR, pc);
    checkOutput("ifid_instr", idx, IFID_INSTR, instr);
    checkOutput("ifid_pc4", idx, IFID_PC4, pc4);
    checkOutput("ifid_valid", idx, {31'b0, IFID_VALID}, {31'b0, valid});
    checkOutput("halted", idx, {31'b0, HALTED}, {31'b0, halted});
  endtask

  task automatic addVec(input logic rst, input logic stall, input logic redirect,
                        input logic [31:0] rpc, input logic [31:0] pc, input logic [31:0] instr,
                        input logic [31:0] pc4, input logic valid, input logic halted);
    vec_t v;
    v.rst = rst; v.stall = stall; v.redirect = redirect; v.redirect_pc = rpc;
    v.exp_pc = pc; v.exp_instr = instr; v.exp_pc4 = pc4;
    v.exp_valid = valid; v.exp_halted = halted;
    vecs.push_back(v);
  endtask

  initial begin
    check_count = 0;
    error_count = 0;
    RST = 1'b1; STALL = 1'b0; REDIRECT = 1'b0; REDIRECT_PC = 32'h0;

    //     rst  stl  red  rpc            pc             instr          pc4           v    h
    addVec(1'b1,1'b0,1'b0,32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000,1'b0,1'b0); // reset
    addVec(1'b0,1'b0,1'b0,32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000,1'b0,1'b0); // boot bubble
    addVec(1'b0,1'b0,1'b0,32'h0000_0000, 32'h0000_0004, 32'h2000_0000, 32'h0000_0004,1'b1,1'b0);
    addVec(1'b0,1'b0,1'b0,32'h0000_0000, 32'h0000_0008, 32'h2000_0004, 32'h0000_0008,1'b1,1'b0);
    addVec(1'b0,1'b1,1'b0,32'h0000_0000, 32'h0000_0008, 32'h2000_0004, 32'h0000_0008,1'b1,1'b0); // stall 1
    addVec(1'b0,1'b1,1'b0,32'h0000_0000, 32'h0000_0008, 32'h2000_0004, 32'h0000_0008,1'b1,1'b0); // stall 2
    addVec(1'b0,1'b0,1'b0,32'h0000_0000, 32'h0000_000C, 32'h2000_0008, 32'h0000_000C,1'b1,1'b0);
    addVec(1'b0,1'b1,1'b1,32'h0000_0103, 32'h0000_0100, 32'h0000_0000, 32'h0000_0000,1'b0,1'b0); // redirect+stall
    addVec(1'b0,1'b0,1'b0,32'h0000_0000, 32'h0000_0104, 32'h2000_0100, 32'h0000_0104,1'b1,1'b0);
    addVec(1'b0,1'b0,1'b1,32'h0000_0016, 32'h0000_0014, 32'h0000_0000, 32'h0000_0000,1'b0,1'b0); // back-to-back
    addVec(1'b0,1'b0,1'b1,32'h0000_001F, 32'h0000_001C, 32'h0000_0000, 32'h0000_0000,1'b0,1'b0);
    addVec(1'b0,1'b0,1'b0,32'h0000_0000, 32'h0000_0020, 32'h2000_001C, 32'h0000_0020,1'b1,1'b0);
    addVec(1'b0,1'b0,1'b0,32'h0000_0000, 32'h0000_0020, 32'h0000_000D, 32'h0000_0024,1'b1,1'b0); // BREAK latched
    addVec(1'b0,1'b0,1'b0,32'h0000_0000, 32'h0000_0020, 32'h0000_0000, 32'h0000_0000,1'b0,1'b1); // halted
    addVec(1'b0,1'b0,1'b1,32'h0000_0040, 32'h0000_0040, 32'h0000_0000, 32'h0000_0000,1'b0,1'b0); // exit halt
    addVec(1'b0,1'b0,1'b0,32'h0000_0000, 32'h0000_0044, 32'h2000_0040, 32'h0000_0044,1'b1,1'b0);
    addVec(1'b0,1'b0,1'b0,32'h0000_0000, 32'h0000_0048, 32'h2000_000D, 32'h0000_0048,1'b1,1'b0); // not BREAK
    addVec(1'b0,1'b0,1'b0,32'h0000_0000, 32'h0000_004C, 32'h0000_0020, 32'h0000_004C,1'b1,1'b0); // not BREAK
    addVec(1'b0,1'b0,1'b1,32'h0000_0020, 32'h0000_0020, 32'h0000_0000, 32'h0000_0000,1'b0,1'b0);
    addVec(1'b0,1'b0,1'b0,32'h0000_0000, 32'h0000_0020, 32'h0000_000D, 32'h0000_0024,1'b1,1'b0); // DRAIN
    addVec(1'b0,1'b1,1'b0,32'h0000_0000, 32'h0000_0020, 32'h0000_000D, 32'h0000_0024,1'b1,1'b0); // stall in DRAIN
    addVec(1'b0,1'b0,1'b1,32'h0000_0080, 32'h0000_0080, 32'h0000_0000, 32'h0000_0000,1'b0,1'b0); // redirect in DRAIN
    addVec(1'b0,1'b0,1'b0,32'h0000_0000, 32'h0000_0084, 32'h2000_0080, 32'h0000_0084,1'b1,1'b0);
    addVec(1'b0,1'b0,1'b1,32'h0000_0020, 32'h0000_0020, 32'h0000_0000, 32'h0000_0000,1'b0,1'b0);
    addVec(1'b0,1'b0,1'b1,32'h0000_003C, 32'h0000_003C, 32'h0000_0000, 32'h0000_0000,1'b0,1'b0); // BREAK+redirect
    addVec(1'b1,1'b0,1'b1,32'h0000_0080, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000,1'b0,1'b0); // reset beats redirect
    addVec(1'b0,1'b1,1'b1,32'h0000_0080, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000,1'b0,1'b0); // BOOT ignores both
    addVec(1'b0,1'b0,1'b0,32'h0000_0000, 32'h0000_0004, 32'h2000_0000, 32'h0000_0004,1'b1,1'b0);
    addVec(1'b0,1'b0,1'b1,32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0000,1'b0,1'b0);
    addVec(1'b0,1'b0,1'b0,32'h0000_0000, 32'h0000_0000, 32'h23FF_FFFC, 32'h0000_0000,1'b1,1'b0); // PC wrap

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].stall, vecs[i].redirect, vecs[i].redirect_pc);
      checkAll(i, vecs[i].exp_pc, vecs[i].exp_instr, vecs[i].exp_pc4,
               vecs[i].exp_valid, vecs[i].exp_halted);
    end

    // Halt held for ten cycles with STALL toggling, then a redirect resumes.
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_0020);
    checkAll(100, 32'h0000_0020, 32'h0, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkAll(101, 32'h0000_0020, 32'h0000_000D, 32'h0000_0024, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkAll(102, 32'h0000_0020, 32'h0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, i[0], 1'b0, 32'h0);
      checkAll(110 + i, 32'h0000_0020, 32'h0, 32'h0, 1'b0, 1'b1);
    end
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_0040);
    checkAll(120, 32'h0000_0040, 32'h0, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkAll(121, 32'h0000_0044, 32'h2000_0040, 32'h0000_0044, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", check_count, error_count);
    $finish;
  end

endmodule
